// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_arbiter
// Description : Round-robin, packet-granular arbiter that shares one
//               byte-wide SPI transmit channel between the FIB (interest
//               packets) and the PIT (data packets). Each packet is framed
//               as a one-cycle TX_valid start pulse followed by its bytes.
//               Optional macro ARB_STATS_EN adds per-owner packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
  parameter int FIB_PKT_BYTES = 9,
  parameter int PIT_PKT_BYTES = 41,
  parameter int CNT_W         = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fib_req,
  input  logic [7:0]  fib_data,
  output logic        fib_byte_ack,
  input  logic        pit_req,
  input  logic [7:0]  pit_data,
  output logic        pit_byte_ack,
  input  logic        spi_tx_ready,
  output logic        TX_valid,
  output logic        TX_byte_valid,
  output logic [7:0]  data_to_SPI,
  output logic [1:0]  grant,
`ifdef ARB_STATS_EN
  output logic [15:0] fib_pkt_cnt,
  output logic [15:0] pit_pkt_cnt,
`endif
  output logic        pkt_done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SOP  = 2'd1;
  localparam logic [1:0] c_SEND = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic c_OWN_FIB = 1'b0;
  localparam logic c_OWN_PIT = 1'b1;

  // Counter value of the final byte of each packet type
  localparam logic [CNT_W-1:0] c_FIB_LAST = CNT_W'(FIB_PKT_BYTES - 1);
  localparam logic [CNT_W-1:0] c_PIT_LAST = CNT_W'(PIT_PKT_BYTES - 1);

  // Packet lengths must be non-zero and reachable by the byte counter
  generate
    if ((FIB_PKT_BYTES < 1) || (PIT_PKT_BYTES < 1) ||
        (FIB_PKT_BYTES > (1 << CNT_W)) || (PIT_PKT_BYTES > (1 << CNT_W))) begin : g_len_check
      $error("spi_tx_arbiter: packet length out of range for CNT_W");
    end
  endgenerate

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_rr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic             w_pick_pit;
  logic             w_ack;

  // Owner selection: on a tie the requester that did not go last wins
  always_comb begin
    if (fib_req && pit_req) begin
      w_pick_pit = (r_rr == c_OWN_FIB);
    end else begin
      w_pick_pit = pit_req;
    end
  end

  assign w_ack        = (r_state == c_SEND) && spi_tx_ready;
  assign fib_byte_ack = w_ack && (r_owner == c_OWN_FIB);
  assign pit_byte_ack = w_ack && (r_owner == c_OWN_PIT);
  assign TX_valid     = (r_state == c_SOP);
  assign pkt_done     = (r_state == c_DONE);
  assign grant        = (r_state == c_IDLE) ? 2'b00 :
                        ((r_owner == c_OWN_PIT) ? 2'b10 : 2'b01);

  // Packet sequencing: arbitration, start pulse, byte counting, hand-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_owner <= c_OWN_FIB;
      r_rr    <= c_OWN_PIT;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (fib_req || pit_req) begin
            r_owner <= w_pick_pit;
            r_last  <= w_pick_pit ? c_PIT_LAST : c_FIB_LAST;
            r_cnt   <= '0;
            r_state <= c_SOP;
          end
        end
        c_SOP: begin
          r_state <= c_SEND;
        end
        c_SEND: begin
          if (w_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_last) begin
              r_state <= c_DONE;
            end
          end
        end
        c_DONE: begin
          r_rr    <= r_owner;
          r_cnt   <= '0;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Byte pipeline: capture the owner's byte on each ack, hold it otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TX_byte_valid <= 1'b0;
      data_to_SPI   <= 8'h00;
    end else if (w_ack) begin
      TX_byte_valid <= 1'b1;
      data_to_SPI   <= (r_owner == c_OWN_PIT) ? pit_data : fib_data;
    end else begin
      TX_byte_valid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating completed-packet counters, one per owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fib_pkt_cnt <= 16'h0000;
      pit_pkt_cnt <= 16'h0000;
    end else if (r_state == c_DONE) begin
      if ((r_owner == c_OWN_FIB) && (fib_pkt_cnt != 16'hFFFF)) begin
        fib_pkt_cnt <= fib_pkt_cnt + 1'b1;
      end
      if ((r_owner == c_OWN_PIT) && (pit_pkt_cnt != 16'hFFFF)) begin
        pit_pkt_cnt <= pit_pkt_cnt + 1'b1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx_arbiter
// Description : Directed self-checking bench for spi_tx_arbiter. A per-cycle
//               scoreboard follows the expected byte stream from fixed
//               source tables; directed tests check arbitration order,
//               latency, stalls and mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        fib_req;
  logic [7:0]  fib_data;
  logic        fib_byte_ack;
  logic        pit_req;
  logic [7:0]  pit_data;
  logic        pit_byte_ack;
  logic        spi_tx_ready;
  logic        TX_valid;
  logic        TX_byte_valid;
  logic [7:0]  data_to_SPI;
  logic [1:0]  grant;
  logic        pkt_done;
`ifdef ARB_STATS_EN
  logic [15:0] fib_pkt_cnt;
  logic [15:0] pit_pkt_cnt;
`endif

  spi_tx_arbiter #(
    .FIB_PKT_BYTES(9),
    .PIT_PKT_BYTES(41),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fib_req(fib_req),
    .fib_data(fib_data),
    .fib_byte_ack(fib_byte_ack),
    .pit_req(pit_req),
    .pit_data(pit_data),
    .pit_byte_ack(pit_byte_ack),
    .spi_tx_ready(spi_tx_ready),
    .TX_valid(TX_valid),
    .TX_byte_valid(TX_byte_valid),
    .data_to_SPI(data_to_SPI),
    .grant(grant),
`ifdef ARB_STATS_EN
    .fib_pkt_cnt(fib_pkt_cnt),
    .pit_pkt_cnt(pit_pkt_cnt),
`endif
    .pkt_done(pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fib_mem [0:8];
  logic [7:0] pit_mem [0:40];
  logic [7:0] cap     [0:63];
  logic [1:0] owners  [$];

  int         cyc = 0;
  int         fib_idx = 0;
  int         pit_idx = 0;
  int         pkt_acks = 0;
  int         cap_n = 0;
  int         sop_cyc = 0;
  int         done_cyc = -100;
  int         first_bv_cyc = 0;
  int         last_gap = 0;
  int         sop_cnt = 0;
  int         done_cnt = 0;
  int         stall_cnt = 0;
  int         pat_pos = 0;
  int         req_cyc = 0;
  int         done_before = 0;
  logic [3:0] ready_pat = 4'b1111;
  logic       in_pkt = 1'b0;
  logic       sending = 1'b0;
  logic       exp_bv = 1'b0;
  logic [7:0] exp_byte = 8'h00;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] cur_grant = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check acks
  task automatic tick();
    logic sop_now;
    @(negedge clk);
    cyc++;
    sop_now = 1'b0;
    if (!rst) begin
      check("rst_tx_valid", TX_valid, 0);
      check("rst_byte_valid", TX_byte_valid, 0);
      check("rst_data", data_to_SPI, 0);
      check("rst_grant", grant, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_acks", {fib_byte_ack, pit_byte_ack}, 0);
      in_pkt    = 1'b0;
      sending   = 1'b0;
      exp_bv    = 1'b0;
      last_byte = 8'h00;
    end else begin
      if (exp_bv) begin
        check("byte_valid", TX_byte_valid, 1);
        check("byte", data_to_SPI, exp_byte);
        if (cap_n == 0) first_bv_cyc = cyc;
        if (cap_n < 64) cap[cap_n] = data_to_SPI;
        cap_n++;
      end else begin
        check("byte_idle", TX_byte_valid, 0);
        check("data_hold", data_to_SPI, last_byte);
      end
      if (TX_valid) begin
        check("sop_unexpected", in_pkt, 0);
        check("grant_onehot", (grant == 2'b01) || (grant == 2'b10), 1);
        sop_now   = 1'b1;
        in_pkt    = 1'b1;
        cur_grant = grant;
        owners.push_back(grant);
        sop_cnt++;
        last_gap  = cyc - done_cyc;
        sop_cyc   = cyc;
        pkt_acks  = 0;
        cap_n     = 0;
        if (grant == 2'b01) fib_idx = 0;
        else pit_idx = 0;
      end
      check("grant", grant, in_pkt ? cur_grant : 2'b00);
      if (pkt_done) begin
        check("done_in_pkt", in_pkt, 1);
        check("done_acks", pkt_acks, (cur_grant == 2'b01) ? 9 : 41);
        check("done_after_last", sending, 0);
        done_cnt++;
        done_cyc = cyc;
        in_pkt   = 1'b0;
      end
    end
    exp_bv       = 1'b0;
    spi_tx_ready = ready_pat[pat_pos];
    pat_pos      = (pat_pos + 1) % 4;
    fib_data     = (fib_idx < 9)  ? fib_mem[fib_idx] : 8'hEE;
    pit_data     = (pit_idx < 41) ? pit_mem[pit_idx] : 8'hEE;
    #1;
    check("fib_ack", fib_byte_ack, sending && spi_tx_ready && (cur_grant == 2'b01));
    check("pit_ack", pit_byte_ack, sending && spi_tx_ready && (cur_grant == 2'b10));
    if (sending && !spi_tx_ready) stall_cnt++;
    if (sending && spi_tx_ready) begin
      exp_bv = 1'b1;
      if (cur_grant == 2'b01) begin
        exp_byte = fib_data;
        fib_idx++;
      end else begin
        exp_byte = pit_data;
        pit_idx++;
      end
      last_byte = exp_byte;
      pkt_acks++;
      if (pkt_acks == ((cur_grant == 2'b01) ? 9 : 41)) sending = 1'b0;
    end
    if (sop_now) sending = 1'b1;
  endtask

  // Run cycles until the next pkt_done, bounded by a cycle budget
  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != start) break;
    end
    check("wait_done_timeout", done_cnt != start, 1);
  endtask

  initial begin
    fib_mem = '{8'h30, 8'h00, 8'h00, 8'hFF, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 41; i++) pit_mem[i] = 8'(i * 5 + 17);
    rst          = 1'b0;
    fib_req      = 1'b1;
    pit_req      = 1'b1;
    spi_tx_ready = 1'b1;
    fib_data     = 8'h00;
    pit_data     = 8'h00;

    // Reset with both requests high, then three arbitrated packets
    repeat (3) tick();
    rst = 1'b1;
    owners.delete();
    tick();
    check("t1_first_sop", TX_valid, 1);
    check("t1_first_grant", grant, 2'b01);
    wait_done(100);
    wait_done(100);
    check("t3_gap_pkt2", last_gap, 2);
    wait_done(100);
    check("t3_gap_pkt3", last_gap, 2);
    fib_req = 1'b0;
    pit_req = 1'b0;
    check("t3_owner_count", owners.size(), 3);
    if (owners.size() == 3) begin
      check("t3_owner0", owners[0], 2'b01);
      check("t3_owner1", owners[1], 2'b10);
      check("t3_owner2", owners[2], 2'b01);
    end
    repeat (3) tick();

    // FIB only, ready always high: latency, occupancy and byte order
    req_cyc = cyc;
    fib_req = 1'b1;
    wait_done(100);
    fib_req = 1'b0;
    check("t2_lat_sop", sop_cyc - req_cyc, 1);
    check("t2_lat_byte", first_bv_cyc - req_cyc, 3);
    check("t2_total", done_cyc - req_cyc + 1, 12);
    tick();
    check("t2_last_byte", cap[8], 8'hA5);
    check("t2_byte0", cap[0], 8'h30);
    check("t2_byte3", cap[3], 8'hFF);
    check("t2_byte_count", cap_n, 9);
    check("t2_grant_idle", grant, 2'b00);
    repeat (2) tick();

    // PIT packet with ready toggled 1,0,0,1
    ready_pat = 4'b1001;
    pat_pos   = 0;
    stall_cnt = 0;
    pit_req   = 1'b1;
    wait_done(400);
    pit_req = 1'b0;
    tick();
    ready_pat = 4'b1111;
    check("t4_owner", owners[owners.size()-1], 2'b10);
    check("t4_stalls_seen", stall_cnt > 0, 1);
    check("t4_byte_count", cap_n, 41);
    check("t4_byte0", cap[0], 8'h11);
    check("t4_byte40", cap[40], 8'hD9);
    repeat (2) tick();

    // Reset in the middle of a FIB packet
    fib_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_pkt && (pkt_acks == 5)) break;
      tick();
    end
    check("t5_reached_byte5", pkt_acks, 5);
    tick();
    done_before = done_cnt;
    rst     = 1'b0;
    fib_req = 1'b0;
    repeat (2) tick();
    check("t5_no_done", done_cnt, done_before);
    rst = 1'b1;
    tick();
    fib_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_pkt && (pkt_acks == 3)) break;
      tick();
    end
    fib_req = 1'b0;
    wait_done(100);
    tick();
    check("t5_restart_done", done_cnt, done_before + 1);
    check("t5_restart_byte0", cap[0], 8'h30);
    check("t5_restart_count", cap_n, 9);

`ifdef ARB_STATS_EN
    // Statistics: counters restarted at the last reset
    fib_req = 1'b1;
    pit_req = 1'b1;
    repeat (4) wait_done(100);
    fib_req = 1'b0;
    pit_req = 1'b0;
    repeat (2) tick();
    check("t6_fib_cnt", fib_pkt_cnt, 16'd3);
    check("t6_pit_cnt", pit_pkt_cnt, 16'd2);
    force dut.fib_pkt_cnt = 16'hFFFF;
    tick();
    release dut.fib_pkt_cnt;
    fib_req = 1'b1;
    wait_done(100);
    fib_req = 1'b0;
    repeat (2) tick();
    check("t6_fib_saturate", fib_pkt_cnt, 16'hFFFF);
    check("t6_pit_unchanged", pit_pkt_cnt, 16'd2);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
